user_pulse_sched: RTL

//  Timed-pulse scheduler for the user domain. SW queues {delay,width} commands over OBI; the block

---
 rtl/user_pulse_sched_pkg.sv | 25 ++
 rtl/user_pulse_sched_fifo.sv | 52 +++++
 rtl/user_pulse_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/user_pulse_sched_pkg.sv
// Shared constants, register map and types for the user-domain timed-pulse scheduler.
package user_pulse_sched_pkg;

    localparam logic [31:0] UserPulseSchedAddrOffset  = 32'h2000_3000;
    localparam logic [31:0] UserPulseSchedAddrRange   = 32'h0000_1000;
    localparam int unsigned UserPulseSched            = 2;
    localparam int unsigned NumUserDomainSubordinates = 3;

    localparam logic [3:0] PulseSchedCtrlOffs   = 4'h0;
    localparam logic [3:0] PulseSchedStatusOffs = 4'h4;
    localparam logic [3:0] PulseSchedPushOffs   = 4'h8;
    localparam logic [3:0] PulseSchedCurOffs    = 4'hC;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_WAIT = 2'd1,
        PS_HIGH = 2'd2
    } pulse_sched_state_e;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] delay;
    } pulse_cmd_t;

endpackage

// File: rtl/user_pulse_sched_fifo.sv
// Command queue with fifo_v3-style ports; a push while full is accepted when a pop frees a slot.
module user_pulse_sched_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    testmode_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  usage_o,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    push_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic                    pop_i
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [AddrW:0]        cnt_q;
    logic                  do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/user_pulse_sched.sv
// Timed-pulse scheduler: OBI register file, command queue and delay/width playback FSM.
module user_pulse_sched
    import user_pulse_sched_pkg::*;
#(
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    input  logic        tick_i,
    output logic        pulse_o,
    output logic        done_irq_o
);

    localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

    pulse_sched_state_e  state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, width_q, width_d;
    logic                enable_q, enable_d, overflow_q, overflow_d;
    logic                rvalid_q, err_q, err_d, done_q, done_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [3:0]          reg_offs;
    logic                addr_err, wr_ok, ctrl_wr, flush, push, pop, abort;
    logic                fifo_full, fifo_empty;
    logic [LvlW-1:0]     fifo_usage;
    pulse_cmd_t          head;
    logic                unused_addr;

    assign unused_addr = ^{obi_addr_i[31:12], obi_addr_i[1:0]};

    assign reg_offs = {obi_addr_i[3:2], 2'b00};
    assign addr_err = |obi_addr_i[11:4];
    assign wr_ok    = obi_req_i && obi_we_i && !addr_err && (obi_be_i == 4'hF);
    assign ctrl_wr  = wr_ok && (reg_offs == PulseSchedCtrlOffs);
    assign flush    = ctrl_wr && obi_wdata_i[1];
    assign push     = wr_ok && (reg_offs == PulseSchedPushOffs) && !flush;
    assign enable_d = ctrl_wr ? obi_wdata_i[0] : enable_q;
    // Abort uses the effective enable so the FSM idles on the same edge enable_q drops.
    assign abort    = !enable_d || flush;
    assign err_d    = obi_req_i && addr_err;

    user_pulse_sched_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (FifoDepth)
    ) i_cmd_fifo (
        .clk_i      (clk_i),
        .rst_ni     (~rst_i),
        .flush_i    (flush),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (obi_wdata_i),
        .push_i     (push),
        .data_o     (head),
        .pop_i      (pop)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (wr_ok && (reg_offs == PulseSchedStatusOffs) && obi_wdata_i[9]) overflow_d = 1'b0;
        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (obi_req_i && !obi_we_i && !addr_err) begin
            case (reg_offs)
                PulseSchedCtrlOffs:   rdata_d = {31'b0, enable_q};
                PulseSchedStatusOffs: rdata_d = {22'b0, overflow_q, state_q != PS_IDLE, 4'b0, 4'(fifo_usage)};
                PulseSchedCurOffs:    rdata_d = {14'b0, state_q, 16'(cnt_q)};
                default:              rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= PS_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            PS_IDLE: begin
                if (enable_q && !fifo_empty && !abort) begin
                    pop     = 1'b1;
                    cnt_d   = CntWidth'(head.delay);
                    width_d = CntWidth'(head.width);
                    state_d = PS_WAIT;
                end
            end
            PS_WAIT: begin
                if (cnt_q == '0) begin
                    cnt_d   = (width_q == '0) ? CntWidth'(1) : width_q;
                    state_d = PS_HIGH;
                end else if (tick_i) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PS_HIGH: begin
                if (tick_i) begin
                    if (cnt_q <= CntWidth'(1)) begin
                        cnt_d   = '0;
                        state_d = PS_IDLE;
                        done_d  = fifo_empty;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = PS_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = PS_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            width_q    <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            rvalid_q   <= obi_req_i;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        obi_gnt_o    = obi_req_i;
        obi_rvalid_o = rvalid_q;
        obi_rdata_o  = rdata_q;
        obi_err_o    = err_q;
        pulse_o      = (state_q == PS_HIGH);
        done_irq_o   = done_q;
    end

endmodule
